bootrom_arbiter: RTL and testbench

- Two-requester arbiter and read sequencer for the synchronous boot ROM (1-cycle registered read).
- Shares the single ROM read port between instruction fetch (IF) and data load (LD).
- Sits between the core's fetch/load units and the bootrom instance; drives the ROM address and returns read data on per-port valid/ready response channels.
- Pipelined: one read per cycle when both responses are accepted. Response backpressure is absorbed by a 1-entry hold register.

---
 rtl/bootrom_arb_pkg.sv | 7 +
 rtl/bootrom_arbiter_if.sv | 29 ++
 rtl/bootrom_arb_pick.sv | 37 +++
 rtl/bootrom_arbiter.sv | 117 +++++++++++
 tb/tb_bootrom_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bootrom_arb_pkg.sv
// Shared types for the boot ROM arbiter: FSM states, requester ids and port count.
package bootrom_arb_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  typedef enum logic {ID_IF = 1'b0, ID_LD = 1'b1} req_id_t;
endpackage

// File: rtl/bootrom_arbiter_if.sv
// Request/response bundle between the fetch/load units (master) and the boot ROM arbiter (slave).
interface bootrom_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_rsp_valid;
  logic                  if_rsp_ready;
  logic                  ld_req_valid;
  logic                  ld_req_ready;
  logic [ADDR_WIDTH-1:0] ld_req_addr;
  logic                  ld_rsp_valid;
  logic                  ld_rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
    output ld_req_valid, ld_req_addr, ld_rsp_ready,
    input  if_req_ready, if_rsp_valid, ld_req_ready, ld_rsp_valid, rsp_data
  );

  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
    input  ld_req_valid, ld_req_addr, ld_rsp_ready,
    output if_req_ready, if_rsp_valid, ld_req_ready, ld_rsp_valid, rsp_data
  );
endinterface

// File: rtl/bootrom_arb_pick.sv
// Combinational winner selection for the boot ROM arbiter.
// BOOTROM_ARB_RR_EN selects round-robin on ties; otherwise IF has fixed priority.
module bootrom_arb_pick
  import bootrom_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_can_issue,
  input  req_id_t            i_last_win,
  output logic [NUM_REQ-1:0] o_grant,
  output req_id_t            o_win
);

`ifndef BOOTROM_ARB_RR_EN
  logic w_unused_last_win;
  assign w_unused_last_win = i_last_win;
`endif

  always_comb begin
    o_win = ID_IF;
`ifdef BOOTROM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    if (i_valid[ID_IF] && i_valid[ID_LD]) begin
      o_win = (i_last_win == ID_IF) ? ID_LD : ID_IF;
    end else if (i_valid[ID_LD]) begin
      o_win = ID_LD;
    end
`else
    if (!i_valid[ID_IF] && i_valid[ID_LD]) begin
      o_win = ID_LD;
    end
`endif
    o_grant = '0;
    if (i_can_issue && (|i_valid)) begin
      o_grant[o_win] = 1'b1;
    end
  end
endmodule

// File: rtl/bootrom_arbiter.sv
// Two-port (IF/LD) arbiter and read sequencer for the 1-cycle synchronous boot ROM.
// Optional round-robin arbitration via BOOTROM_ARB_RR_EN (default: fixed IF priority).
module bootrom_arbiter
  import bootrom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  bootrom_arbiter_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata
);

  state_t                r_state;
  state_t                w_next_state;
  req_id_t               r_id_q;
  logic [DATA_WIDTH-1:0] r_hold_q;
  logic [ADDR_WIDTH-1:0] r_last_addr_q;
  req_id_t               w_last_win;
  logic                  w_sel_rsp_ready;
  logic                  w_can_issue;
  logic [NUM_REQ-1:0]    w_valid;
  logic [NUM_REQ-1:0]    w_grant;
  req_id_t               w_win;
  logic                  w_granted;

  assign w_sel_rsp_ready = (r_id_q == ID_IF) ? bus.if_rsp_ready : bus.ld_rsp_ready;
  // Any non-IDLE state is presenting a response, so an accept frees the ROM port.
  assign w_can_issue     = !reset && ((r_state == IDLE) || w_sel_rsp_ready);
  assign w_valid         = {bus.ld_req_valid, bus.if_req_valid};
  assign w_granted       = |w_grant;

  bootrom_arb_pick u_pick (
    .i_valid    (w_valid),
    .i_can_issue(w_can_issue),
    .i_last_win (w_last_win),
    .o_grant    (w_grant),
    .o_win      (w_win)
  );

`ifdef BOOTROM_ARB_RR_EN
  req_id_t r_last_win_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_win_q <= ID_LD;
    end else if (w_granted) begin
      r_last_win_q <= w_win;
    end
  end

  assign w_last_win = r_last_win_q;
`else
  assign w_last_win = ID_LD;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = w_granted ? RESP : IDLE;
      RESP,
      HOLD: begin
        if (w_sel_rsp_ready) begin
          w_next_state = w_granted ? RESP : IDLE;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_q        <= ID_IF;
      r_hold_q      <= '0;
      r_last_addr_q <= '0;
    end else begin
      if (w_granted) begin
        r_id_q        <= w_win;
        r_last_addr_q <= rom_addr;
      end
      // Capture the ROM word on the first stalled cycle; HOLD serves it from here.
      if ((r_state == RESP) && !w_sel_rsp_ready) begin
        r_hold_q <= rom_rdata;
      end
    end
  end

  always_comb begin
    bus.if_req_ready = w_grant[ID_IF];
    bus.ld_req_ready = w_grant[ID_LD];
    bus.if_rsp_valid = (r_state != IDLE) && (r_id_q == ID_IF);
    bus.ld_rsp_valid = (r_state != IDLE) && (r_id_q == ID_LD);
    case (r_state)
      RESP:    bus.rsp_data = rom_rdata;
      HOLD:    bus.rsp_data = r_hold_q;
      default: bus.rsp_data = '0;
    endcase
    // Re-presenting the last address keeps rom_rdata stable when nothing is issued.
    if (w_granted) begin
      rom_addr = (w_win == ID_LD) ? bus.ld_req_addr : bus.if_req_addr;
    end else begin
      rom_addr = r_last_addr_q;
    end
  end
endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed self-checking bench for bootrom_arbiter with a behavioural 1-cycle ROM.
module tb_bootrom_arbiter;
  import bootrom_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [63:0] rom_rdata;
  int          n_checks;
  int          n_errors;

  bootrom_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) bus ();

  bootrom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_rdata(rom_rdata)
  );

  function automatic logic [63:0] rom_word(input logic [7:0] a);
    return {32'hDEADBEEF, 24'h000000, a};
  endfunction

  always @(posedge clk) rom_rdata <= rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  req_id_t     exp_win;
  req_id_t     prev_win;
  logic [7:0]  prev_addr;
  logic [7:0]  a;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h05;
    bus.if_rsp_ready = 1'b1;
    bus.ld_req_valid = 1'b0;
    bus.ld_req_addr  = 8'h00;
    bus.ld_rsp_ready = 1'b1;

    // Reset state, with an IF request already pending
    @(negedge clk); #1;
    chk("rst_if_req_ready", 64'(bus.if_req_ready), 64'd0);
    chk("rst_ld_req_ready", 64'(bus.ld_req_ready), 64'd0);
    chk("rst_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
    chk("rst_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);

    // Single IF read of address 5, granted in the first cycle after release
    @(negedge clk);
    reset = 1'b0; #1;
    chk("single_if_req_ready", 64'(bus.if_req_ready), 64'd1);
    chk("single_rom_addr", 64'(rom_addr), 64'h05);
    @(negedge clk);
    bus.if_req_valid = 1'b0; #1;
    chk("single_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
    chk("single_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd0);
    chk("single_rsp_data", bus.rsp_data, 64'hDEADBEEF00000005);
    @(negedge clk); #1;
    chk("single_idle_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);

    // Contention: both requesting every cycle, both accepting
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h10;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 8'h20;
    prev_win  = ID_IF;
    prev_addr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef BOOTROM_ARB_RR_EN
      exp_win = (k % 2 == 1) ? ID_LD : ID_IF;
`else
      exp_win = ID_IF;
`endif
      chk("cont_if_req_ready", 64'(bus.if_req_ready), 64'(exp_win == ID_IF));
      chk("cont_ld_req_ready", 64'(bus.ld_req_ready), 64'(exp_win == ID_LD));
      chk("cont_rom_addr", 64'(rom_addr), (exp_win == ID_IF) ? 64'h10 : 64'h20);
      if (k > 0) begin
        chk("cont_if_rsp_valid", 64'(bus.if_rsp_valid), 64'(prev_win == ID_IF));
        chk("cont_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'(prev_win == ID_LD));
        chk("cont_rsp_data", bus.rsp_data, rom_word(prev_addr));
      end
      prev_win  = exp_win;
      prev_addr = (exp_win == ID_IF) ? 8'h10 : 8'h20;
      @(negedge clk);
    end
    bus.if_req_valid = 1'b0;
    bus.ld_req_valid = 1'b0; #1;
    chk("cont_drain_valid", 64'(prev_win == ID_IF ? bus.if_rsp_valid : bus.ld_rsp_valid), 64'd1);
    chk("cont_drain_data", bus.rsp_data, rom_word(prev_addr));
    @(negedge clk); #1;
    chk("cont_idle_if", 64'(bus.if_rsp_valid), 64'd0);
    chk("cont_idle_ld", 64'(bus.ld_rsp_valid), 64'd0);

    // Backpressure: IF addr 3 stalled 3 cycles while LD waits for addr 7
    @(negedge clk);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h03; #1;
    chk("bp_if_req_ready", 64'(bus.if_req_ready), 64'd1);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 8'h07;
    bus.if_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
      chk("bp_stall_rsp_data", bus.rsp_data, rom_word(8'h03));
      chk("bp_stall_ld_req_ready", 64'(bus.ld_req_ready), 64'd0);
      chk("bp_stall_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd0);
      @(negedge clk);
    end
    bus.if_rsp_ready = 1'b1; #1;
    chk("bp_accept_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
    chk("bp_accept_rsp_data", bus.rsp_data, rom_word(8'h03));
    chk("bp_accept_ld_req_ready", 64'(bus.ld_req_ready), 64'd1);
    chk("bp_accept_rom_addr", 64'(rom_addr), 64'h07);
    @(negedge clk);
    bus.ld_req_valid = 1'b0; #1;
    chk("bp_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd1);
    chk("bp_if_rsp_valid_low", 64'(bus.if_rsp_valid), 64'd0);
    chk("bp_ld_rsp_data", bus.rsp_data, rom_word(8'h07));
    @(negedge clk); #1;
    chk("bp_idle_ld", 64'(bus.ld_rsp_valid), 64'd0);

    // Streaming 250..255,0..3 with a wrap and no bubbles
    for (int k = 0; k < 11; k++) begin
      a = 8'(250 + k);
      bus.if_req_valid = (k < 10);
      bus.if_req_addr  = a; #1;
      if (k < 10) begin
        chk("stream_if_req_ready", 64'(bus.if_req_ready), 64'd1);
        chk("stream_rom_addr", 64'(rom_addr), 64'(a));
      end
      if (k > 0) begin
        chk("stream_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
        chk("stream_rsp_data", bus.rsp_data, rom_word(8'(a - 8'd1)));
      end
      @(negedge clk);
    end
    #1;
    chk("stream_end_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);

    // Reset asserted while a response is held
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h09;
    bus.if_rsp_ready = 1'b0; #1;
    chk("rh_if_req_ready", 64'(bus.if_req_ready), 64'd1);
    @(negedge clk);
    bus.if_req_valid = 1'b0; #1;
    chk("rh_resp_valid", 64'(bus.if_rsp_valid), 64'd1);
    @(negedge clk); #1;
    chk("rh_hold_valid", 64'(bus.if_rsp_valid), 64'd1);
    chk("rh_hold_data", bus.rsp_data, rom_word(8'h09));
    reset = 1'b1; #1;
    chk("rh_async_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
    chk("rh_async_rsp_data", bus.rsp_data, 64'd0);
    chk("rh_async_rom_addr", 64'(rom_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.if_rsp_ready = 1'b1; #1;
    chk("rh_post_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
    chk("rh_post_ld_rsp_valid", 64'(bus.ld_rsp_valid), 64'd0);
    @(negedge clk); #1;
    chk("rh_idle_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd0);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 8'h42; #1;
    chk("rh_new_if_req_ready", 64'(bus.if_req_ready), 64'd1);
    chk("rh_new_rom_addr", 64'(rom_addr), 64'h42);
    @(negedge clk);
    bus.if_req_valid = 1'b0; #1;
    chk("rh_new_if_rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
    chk("rh_new_rsp_data", bus.rsp_data, rom_word(8'h42));
    @(negedge clk); #1;
    chk("rh_final_idle", 64'(bus.if_rsp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
